opb_register_simulink2ppc: RTL and testbench
============================================

# opb_register_simulink2ppc

Read-only OPB slave register carrying a 32-bit word from fabric user logic to the PowerPC; the return path of the PPC-to-fabric control register. User logic presents a word with a valid strobe. The block latches it, tracks whether the PPC has read it, and counts overruns. The PPC reads data and status over OPB at C_BASEADDR.

## Interface
Parameters:
- C_BASEADDR, 32'hFFFFFFFF: first byte address of the slave window
- C_HIGHADDR, 32'h00000000: last byte address of the window; minimum window 8 bytes
- C_OPB_AWIDTH, 32: OPB address width
- C_OPB_DWIDTH, 32: OPB data width
- C_FAMILY, "virtex5": target family; informational only

Ports:
- OPB_Clk  in  1  single clock for bus and user side
- OPB_Rst  in  1  asynchronous, active-high reset
- OPB_ABus  in  [0:31]  byte address; bit 0 is the MSB
- OPB_BE  in  [0:3]  byte enables; ignored, all accesses treated as 32-bit
- OPB_DBus  in  [0:31]  write data; ignored
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  burst hint; ignored
- Sl_DBus  out  [0:31]  read data; all zero except during the ack cycle
- Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0
- user_data_in  in  [31:0]  word from user logic
- user_data_valid  in  1  one-cycle capture strobe
- user_data_pending  out  1  mirror of the NEW flag

## Operation
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset = OPB_ABus - C_BASEADDR, with bits [1:0] ignored.
- Offset 0x0, DATA, read: returns the data register and clears NEW. Writes are acked and ignored.
- Offset 0x4, STATUS, read: returns {16'h0, ovr[7:0], 7'h0, NEW}, LSB = Sl_DBus[31]. Any write clears ovr to 0.
- Offsets 0x8 and above inside the window: reads return 0, writes are acked and ignored.
- Capture: user_data_valid=1 loads user_data_in into the data register and sets NEW.
  - If NEW was already 1 at that edge, ovr increments.
  - ovr saturates at 8'hFF.
- Same-cycle events, resolved in the ACK cycle:
  - Capture and DATA read together: the read returns the old word, and NEW ends at 1.
  - Overrun increment and STATUS write together: the clear wins, and ovr ends at 0.
- FSM states:
  - IDLE → ACK when there is a hit.
  - ACK → IDLE unconditionally.
  - If select stays high in IDLE, that starts a new transfer. A burst is therefore acked at most every second cycle.
- Reset values: Sl_DBus=0, Sl_xferAck=0, data register=0, NEW=0, ovr=0, user_data_pending=0, state=IDLE.
- Reset during ACK drops the ack immediately. The master relies on its own bus timeout; no partial side effects are committed.

## Timing
- Cycle N: select and hit sampled in IDLE. Read data is muxed from the registers as they stand at edge N, then registered.
- Cycle N+1: Sl_xferAck=1 and Sl_DBus valid. Side effects (NEW clear, ovr clear) take effect at the end of N+1.
- Read latency is 1 cycle from select to ack, so a transfer occupies 2 cycles.
- Sl_DBus is forced to 0 whenever Sl_xferAck=0, as required by the wired-OR bus.
- Capture latency: data register and user_data_pending update one edge after user_data_valid.

## Structure
- Shared package opb_s2p_pkg holds:
  - OFFS_DATA=0x0, OFFS_STATUS=0x4
  - STATUS_NEW_BIT=0, STATUS_OVR_LSB=8, STATUS_OVR_W=8
  - FSM state typedef {IDLE, ACK}
- Sub-module opb_s2p_bus_fsm does address decode, the IDLE/ACK FSM and the ack/zero-gating of Sl_DBus. It outputs rd_data_strobe, wr_status_strobe and a registered offset.
- Top level holds the data register, the NEW flag and the ovr counter.

## Test plan
- Reset then read DATA and STATUS: each ack arrives 1 cycle after select, and both return 0x00000000.
- Capture 0xDEADBEEF, then read STATUS → 0x00000001. Read DATA → 0xDEADBEEF. Read STATUS again → 0x00000000.
- Capture 300 words with no read: STATUS = 0x0000FF01 (ovr saturated at 255). Write STATUS → STATUS reads 0x00000001.
- Capture 0x12345678 on the exact ACK cycle of a DATA read that had 0xAAAAAAAA latched: read returns 0xAAAAAAAA, NEW=1 afterwards, and the next DATA read returns 0x12345678.
- Select held for 6 cycles at offset 0x4, and an access at C_HIGHADDR+4: the held select produces acks on alternating cycles (3 acks), and the out-of-window access produces no ack with Sl_DBus=0.
- Assert OPB_Rst during ACK with NEW=1: Sl_xferAck drops in the same cycle, and all registers read 0 after reset.

Source files
------------

// File: rtl/opb_s2p_pkg.sv
// Shared constants and types for the fabric-to-PPC OPB status/data register.
// Register offsets, STATUS bit layout and the bus FSM state encoding.
package opb_s2p_pkg;

  localparam logic [31:0] OFFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFFS_STATUS = 32'h0000_0004;

  localparam int STATUS_NEW_BIT = 0;
  localparam int STATUS_OVR_LSB = 8;
  localparam int STATUS_OVR_W   = 8;

  localparam logic [STATUS_OVR_W-1:0] OVR_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  function automatic logic [31:0] make_status(input logic [STATUS_OVR_W-1:0] ovr,
                                              input logic                    new_flag);
    logic [31:0] w;
    w = '0;
    w[STATUS_OVR_LSB +: STATUS_OVR_W] = ovr;
    w[STATUS_NEW_BIT]                 = new_flag;
    return w;
  endfunction

endpackage

// File: rtl/opb_s2p_bus_fsm.sv
// OPB slave decode + IDLE/ACK handshake; ack one cycle after select, so a transfer takes 2 cycles.
// No backpressure: a held select is re-sampled in IDLE, giving at most one ack every second cycle.
module opb_s2p_bus_fsm
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'hFFFF_FFFF,
  parameter logic [31:0] HIGHADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] abus,
  input  logic        rnw,
  input  logic        select,
  input  logic [31:0] data_word,
  input  logic [31:0] status_word,
  output logic [31:0] dbus,
  output logic        xfer_ack,
  output logic        rd_data_strobe,
  output logic        wr_status_strobe,
  output logic [31:0] offset
);

  state_t      state;
  state_t      state_nxt;
  logic        hit;
  logic [31:0] cur_off;
  logic [31:0] rd_mux;
  logic        rnw_q;
  logic [31:0] dbus_q;

  assign hit     = select && (abus >= BASEADDR) && (abus <= HIGHADDR);
  assign cur_off = (abus - BASEADDR) & ~32'h3;

  always_comb begin
    rd_mux = '0;
    if (cur_off == OFFS_DATA) begin
      rd_mux = data_word;
    end else if (cur_off == OFFS_STATUS) begin
      rd_mux = status_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Side-effect strobes fire in the ack cycle so they land at its closing edge.
  always_comb begin
    xfer_ack         = (state == ACK);
    rd_data_strobe   = xfer_ack && rnw_q && (offset == OFFS_DATA);
    wr_status_strobe = xfer_ack && !rnw_q && (offset == OFFS_STATUS);
    dbus             = xfer_ack ? dbus_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
      rnw_q  <= 1'b1;
      dbus_q <= '0;
    end else if (state == IDLE) begin
      dbus_q <= (hit && rnw) ? rd_mux : '0;
      if (hit) begin
        offset <= cur_off;
        rnw_q  <= rnw;
      end
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Read-only OPB register returning a user-logic word to the PPC, with NEW flag and saturating overrun count.
// Capture lands one edge after user_data_valid; the bus side never stalls user logic.
module opb_register_simulink2ppc
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_data_pending
);

  localparam string family_unused = C_FAMILY;

  logic [31:0]             data_q;
  logic                    new_q;
  logic [STATUS_OVR_W-1:0] ovr_q;
  logic [31:0]             abus;
  logic [31:0]             dbus;
  logic [31:0]             status_word;
  logic                    xfer_ack;
  logic                    rd_data_strobe;
  logic                    wr_status_strobe;
  logic [31:0]             unused_offset;
  logic                    unused_inputs;

  // Big-endian bus numbering keeps the same numeric value, so plain assignment converts it.
  assign abus          = OPB_ABus;
  assign unused_inputs = ^{OPB_BE, OPB_DBus, OPB_seqAddr};
  assign status_word   = make_status(ovr_q, new_q);

  opb_s2p_bus_fsm #(
    .BASEADDR (C_BASEADDR),
    .HIGHADDR (C_HIGHADDR)
  ) u_bus_fsm (
    .clk              (OPB_Clk),
    .rst              (OPB_Rst),
    .abus             (abus),
    .rnw              (OPB_RNW),
    .select           (OPB_select),
    .data_word        (data_q),
    .status_word      (status_word),
    .dbus             (dbus),
    .xfer_ack         (xfer_ack),
    .rd_data_strobe   (rd_data_strobe),
    .wr_status_strobe (wr_status_strobe),
    .offset           (unused_offset)
  );

  // A capture on the read's ack edge beats the clear, so the fresh word stays flagged.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_q <= '0;
      new_q  <= 1'b0;
    end else if (user_data_valid) begin
      data_q <= user_data_in;
      new_q  <= 1'b1;
    end else if (rd_data_strobe) begin
      new_q <= 1'b0;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ovr_q <= '0;
    end else if (wr_status_strobe) begin
      ovr_q <= '0;
    end else if (user_data_valid && new_q && (ovr_q != OVR_MAX)) begin
      ovr_q <= ovr_q + 1'b1;
    end
  end

  assign Sl_DBus           = dbus;
  assign Sl_xferAck        = xfer_ack;
  assign Sl_errAck         = 1'b0;
  assign Sl_retry          = 1'b0;
  assign Sl_toutSup        = 1'b0;
  assign user_data_pending = new_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Bench for opb_register_simulink2ppc: directed scenarios plus random traffic
// against a cycle-level reference of the register's read/capture rules.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] HIGH = 32'h4000_000F;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic        rnw;
  logic        sel;
  logic        seq;
  logic [31:0] dbus;
  logic        ack;
  logic        err;
  logic        retry;
  logic        tout;
  logic [31:0] din;
  logic        valid;
  logic        pend;

  opb_register_simulink2ppc #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH)
  ) dut (
    .OPB_Clk           (clk),
    .OPB_Rst           (rst),
    .OPB_ABus          (addr),
    .OPB_BE            (be),
    .OPB_DBus          (wdat),
    .OPB_RNW           (rnw),
    .OPB_select        (sel),
    .OPB_seqAddr       (seq),
    .Sl_DBus           (dbus),
    .Sl_xferAck        (ack),
    .Sl_errAck         (err),
    .Sl_retry          (retry),
    .Sl_toutSup        (tout),
    .user_data_in      (din),
    .user_data_valid   (valid),
    .user_data_pending (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference register contents
  logic [31:0] m_data;
  bit          m_new;
  int          m_ovr;
  // Expected bus phase for the cycle just entered
  bit          e_ack;
  bit          e_rnw;
  logic [31:0] e_off;
  logic [31:0] e_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    if (off == 32'h0) return m_data;
    if (off == 32'h4) return 32'(m_ovr * 256 + int'(m_new));
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_new   = 1'b0;
    m_ovr   = 0;
    e_ack   = 1'b0;
    e_rnw   = 1'b1;
    e_off   = '0;
    e_rdata = '0;
  endtask

  // One clock: predict from pre-edge inputs, advance the reference, then check DUT outputs.
  task automatic cycle();
    bit          hit;
    bit          nxt_ack;
    bit          old_new;
    bit          ovr_clr;
    logic [31:0] off;
    logic [31:0] nxt_rdata;
    hit       = sel && (addr >= BASE) && (addr <= HIGH);
    off       = (addr - BASE) & ~32'h3;
    nxt_ack   = !e_ack && hit;
    nxt_rdata = (nxt_ack && rnw) ? model_read(off) : 32'h0;
    @(posedge clk);
    old_new = m_new;
    ovr_clr = e_ack && !e_rnw && (e_off == 32'h4);
    if (e_ack && e_rnw && (e_off == 32'h0)) m_new = 1'b0;
    if (valid) begin
      if (old_new && m_ovr < 255) m_ovr++;
      m_data = din;
      m_new  = 1'b1;
    end
    if (ovr_clr) m_ovr = 0;
    if (nxt_ack) begin
      e_rnw = rnw;
      e_off = off;
    end
    e_ack   = nxt_ack;
    e_rdata = nxt_rdata;
    #1;
    chk("ack", ack, e_ack);
    chk("dbus", dbus, e_ack ? e_rdata : 32'h0);
    chk("pending", pend, m_new);
    chk("const_zero", {err, retry, tout}, 3'b000);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel  = 1'b1;
    rnw  = 1'b1;
    addr = a;
    cycle();
    sel = 1'b0;
    d   = dbus;
    chk("read_latency", ack, 1'b1);
    cycle();
  endtask

  task automatic bus_write(input logic [31:0] a);
    sel  = 1'b1;
    rnw  = 1'b0;
    addr = a;
    wdat = $urandom;
    cycle();
    sel = 1'b0;
    chk("write_latency", ack, 1'b1);
    cycle();
    rnw = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int          acks;
    int          pick;
    rst   = 1'b1;
    addr  = '0;
    be    = 4'hF;
    wdat  = '0;
    rnw   = 1'b1;
    sel   = 1'b0;
    seq   = 1'b0;
    din   = '0;
    valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", ack, 1'b0);
    chk("reset_dbus", dbus, 32'h0);
    chk("reset_pending", pend, 1'b0);
    rst = 1'b0;

    bus_read(BASE, d);
    chk("reset_data", d, 32'h0);
    bus_read(BASE + 32'h4, d);
    chk("reset_status", d, 32'h0);

    valid = 1'b1;
    din   = 32'hDEAD_BEEF;
    cycle();
    valid = 1'b0;
    bus_read(BASE + 32'h4, d);
    chk("status_new", d, 32'h0000_0001);
    bus_read(BASE, d);
    chk("data_beef", d, 32'hDEAD_BEEF);
    bus_read(BASE + 32'h4, d);
    chk("status_cleared", d, 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      valid = 1'b1;
      din   = $urandom;
      cycle();
    end
    valid = 1'b0;
    bus_read(BASE + 32'h4, d);
    chk("status_ovr_sat", d, 32'h0000_FF01);
    bus_write(BASE + 32'h4);
    bus_read(BASE + 32'h4, d);
    chk("status_ovr_clr", d, 32'h0000_0001);

    valid = 1'b1;
    din   = 32'hAAAA_AAAA;
    cycle();
    valid = 1'b0;
    sel   = 1'b1;
    rnw   = 1'b1;
    addr  = BASE;
    cycle();
    sel   = 1'b0;
    valid = 1'b1;
    din   = 32'h1234_5678;
    chk("race_old_word", dbus, 32'hAAAA_AAAA);
    cycle();
    valid = 1'b0;
    chk("race_new_kept", pend, 1'b1);
    bus_read(BASE, d);
    chk("race_next_word", d, 32'h1234_5678);

    sel  = 1'b1;
    rnw  = 1'b1;
    addr = BASE + 32'h4;
    acks = 0;
    repeat (6) begin
      cycle();
      acks += int'(ack);
    end
    sel = 1'b0;
    cycle();
    chk("burst_acks", acks, 3);
    sel  = 1'b1;
    addr = HIGH + 32'h4;
    acks = 0;
    repeat (2) begin
      cycle();
      acks += int'(ack);
    end
    sel = 1'b0;
    chk("out_of_window_acks", acks, 0);
    bus_read(BASE + 32'h8, d);
    chk("reserved_offset", d, 32'h0);

    valid = 1'b1;
    din   = 32'h0000_0055;
    cycle();
    valid = 1'b0;
    sel   = 1'b1;
    rnw   = 1'b1;
    addr  = BASE;
    cycle();
    sel = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ack_drop", ack, 1'b0);
    chk("rst_in_ack_dbus", dbus, 32'h0);
    chk("rst_in_ack_pending", pend, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus_read(BASE, d);
    chk("post_rst_data", d, 32'h0);
    bus_read(BASE + 32'h4, d);
    chk("post_rst_status", d, 32'h0);

    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      din   = $urandom;
      sel   = ($urandom_range(0, 1) == 1);
      rnw   = ($urandom_range(0, 3) != 0);
      wdat  = $urandom;
      pick  = $urandom_range(0, 5);
      case (pick)
        0:       addr = BASE;
        1:       addr = BASE + 32'h4;
        2:       addr = BASE + 32'h8 + 32'($urandom_range(0, 7));
        3:       addr = BASE - 32'h4;
        4:       addr = HIGH + 32'h1;
        default: addr = BASE + 32'h4 + 32'($urandom_range(0, 3));
      endcase
      cycle();
    end
    valid = 1'b0;
    sel   = 1'b0;
    cycle();
    bus_read(BASE + 32'h4, d);
    chk("final_status", d, 32'(m_ovr * 256 + int'(m_new)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
